systolic_matmul_unit: RTL and testbench

- Signed DIM x DIM matrix-multiply engine: C += A x B.
- Contains three parts:
  - A-side row memory, which skews rows of A into the array.
  - B-side skew delay lines, which skew rows of B into the array.
  - Output-stationary systolic array of DIM x DIM MAC processing elements (PEs), each holding one C element.
- C rows are read and written through a row-addressed port.
- Sits between the host load/store datapath and the accelerator control logic.

---
 rtl/systolic_matmul_unit.sv | 179 +++++++++++++++++
 tb/tb_systolic_matmul_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_matmul_unit.sv
// Signed DIM x DIM output-stationary systolic matmul (C += A x B); A row memory + B skew lines feed the PE grid.
// Latency: last product lands at en edge 3*DIM-2 of the load protocol; C port read is combinational, write takes one edge.
// No backpressure: all skew/PE state advances only on en and holds otherwise. Optional MAC_SATURATE_EN clamps each accumulate.
module systolic_matmul_unit #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8,
  parameter int ROWBITS = $clog2(DIM)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            WrEnA,
  input  logic [ROWBITS-1:0]              Arow,
  input  logic [DIM-1:0][BITS_AB-1:0]     Ain,
  input  logic [DIM-1:0][BITS_AB-1:0]     Bin,
  input  logic                            WrEnC,
  input  logic [ROWBITS-1:0]              Crow,
  input  logic [DIM-1:0][BITS_C-1:0]      Cin,
  output logic [DIM-1:0][BITS_C-1:0]      Cout,
  output logic [DIM-1:0][BITS_AB-1:0]     Aout,
  output logic [DIM-1:0][BITS_AB-1:0]     Bout
);

  localparam int PW = 2 * BITS_AB;
  localparam int WW = (PW > BITS_C) ? PW : BITS_C;

  // One multiply-accumulate step: product sign-extended/truncated to BITS_C, then wrapped or clamped.
  function automatic logic [BITS_C-1:0] mac(input logic [BITS_C-1:0]  acc,
                                            input logic [BITS_AB-1:0] a,
                                            input logic [BITS_AB-1:0] b);
    logic signed [PW-1:0] prod;
    logic signed [WW-1:0] prod_w;
`ifdef MAC_SATURATE_EN
    logic signed [BITS_C:0] sum;
`endif
    prod   = $signed(a) * $signed(b);
    prod_w = prod;
`ifdef MAC_SATURATE_EN
    sum = $signed({acc[BITS_C-1], acc}) + $signed({prod_w[BITS_C-1], prod_w[BITS_C-1:0]});
    if (sum[BITS_C] != sum[BITS_C-1]) begin
      mac = sum[BITS_C] ? {1'b1, {(BITS_C-1){1'b0}}} : {1'b0, {(BITS_C-1){1'b1}}};
    end else begin
      mac = sum[BITS_C-1:0];
    end
`else
    mac = acc + prod_w[BITS_C-1:0];
`endif
  endfunction

  // ---------------- A row memory ----------------
  logic [BITS_AB-1:0] a_buf_q [DIM][DIM];
  logic [BITS_AB-1:0] a_buf_d [DIM][DIM];

  // Per-row: a load replaces that row's buffer; otherwise en shifts toward the head with 0 at the tail.
  always_comb begin
    for (int r = 0; r < DIM; r++) begin
      for (int j = 0; j < DIM; j++) begin
        a_buf_d[r][j] = a_buf_q[r][j];
      end
      if (WrEnA && (Arow == ROWBITS'(r))) begin
        for (int j = 0; j < DIM; j++) begin
          a_buf_d[r][j] = Ain[j];
        end
      end else if (en) begin
        for (int j = 0; j < DIM - 1; j++) begin
          a_buf_d[r][j] = a_buf_q[r][j+1];
        end
        a_buf_d[r][DIM-1] = '0;
      end
    end
  end

  // A buffer registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM; r++) begin
        for (int j = 0; j < DIM; j++) begin
          a_buf_q[r][j] <= '0;
        end
      end
    end else begin
      a_buf_q <= a_buf_d;
    end
  end

  // Head entry of each row buffer feeds array row r.
  always_comb begin
    for (int r = 0; r < DIM; r++) begin
      Aout[r] = a_buf_q[r][0];
    end
  end

  // ---------------- B skew lines ----------------
  for (genvar c = 0; c < DIM; c++) begin : g_bcol
    logic [BITS_AB-1:0] chain_q [c+1];

    // Column c delays Bin[c] by c extra en edges so column c starts c beats late.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int s = 0; s <= c; s++) begin
          chain_q[s] <= '0;
        end
      end else if (en) begin
        chain_q[0] <= Bin[c];
        for (int s = 1; s <= c; s++) begin
          chain_q[s] <= chain_q[s-1];
        end
      end
    end

    assign Bout[c] = chain_q[c];
  end

  // ---------------- PE grid ----------------
  logic [BITS_AB-1:0] a_q   [DIM][DIM];
  logic [BITS_AB-1:0] b_q   [DIM][DIM];
  logic [BITS_C-1:0]  acc_q [DIM][DIM];
  logic [BITS_C-1:0]  acc_d [DIM][DIM];
  logic [BITS_AB-1:0] a_in  [DIM][DIM];
  logic [BITS_AB-1:0] b_in  [DIM][DIM];

  // Operand routing: A flows left-to-right along rows, B top-to-bottom along columns.
  always_comb begin
    for (int r = 0; r < DIM; r++) begin
      a_in[r][0] = Aout[r];
      for (int c = 1; c < DIM; c++) begin
        a_in[r][c] = a_q[r][c-1];
      end
    end
    for (int c = 0; c < DIM; c++) begin
      b_in[0][c] = Bout[c];
      for (int r = 1; r < DIM; r++) begin
        b_in[r][c] = b_q[r-1][c];
      end
    end
  end

  // Accumulator next state: a host write to row Crow beats the MAC on that row only.
  always_comb begin
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        acc_d[r][c] = acc_q[r][c];
        if (WrEnC && (Crow == ROWBITS'(r))) begin
          acc_d[r][c] = Cin[c];
        end else if (en) begin
          acc_d[r][c] = mac(acc_q[r][c], a_in[r][c], b_in[r][c]);
        end
      end
    end
  end

  // PE operand pipeline and accumulators with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          a_q[r][c]   <= '0;
          b_q[r][c]   <= '0;
          acc_q[r][c] <= '0;
        end
      end
    end else begin
      if (en) begin
        a_q <= a_in;
        b_q <= b_in;
      end
      acc_q <= acc_d;
    end
  end

  // Row-addressed combinational C read.
  always_comb begin
    for (int c = 0; c < DIM; c++) begin
      Cout[c] = acc_q[Crow][c];
    end
  end

endmodule

// File: tb/tb_systolic_matmul_unit.sv
// Directed bench for systolic_matmul_unit: reset, skew timing, identity, signed wrap, hold, write priority, random runs.
module tb_systolic_matmul_unit;
  localparam int BITS_AB = 8;
  localparam int BITS_C  = 16;
  localparam int DIM     = 8;
  localparam int ROWBITS = 3;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        en;
  logic                        WrEnA;
  logic [ROWBITS-1:0]          Arow;
  logic [DIM-1:0][BITS_AB-1:0] Ain;
  logic [DIM-1:0][BITS_AB-1:0] Bin;
  logic                        WrEnC;
  logic [ROWBITS-1:0]          Crow;
  logic [DIM-1:0][BITS_C-1:0]  Cin;
  logic [DIM-1:0][BITS_C-1:0]  Cout;
  logic [DIM-1:0][BITS_AB-1:0] Aout;
  logic [DIM-1:0][BITS_AB-1:0] Bout;

  int checks   = 0;
  int failures = 0;
  int A [DIM][DIM];
  int B [DIM][DIM];
  logic [BITS_C-1:0] expc [DIM][DIM];

  systolic_matmul_unit #(
    .BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM), .ROWBITS(ROWBITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .WrEnA(WrEnA), .Arow(Arow), .Ain(Ain),
    .Bin(Bin), .WrEnC(WrEnC), .Crow(Crow), .Cin(Cin), .Cout(Cout),
    .Aout(Aout), .Bout(Bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference element: terms consumed at edges after after_edge, starting from base.
  function automatic logic [BITS_C-1:0] ref_elem(input int r, input int c, input int base, input int after_edge);
    int s;
    logic [31:0] t;
    s = base;
    for (int k = 0; k < DIM; k++) begin
      if (r + k + c + 1 > after_edge) begin
        s = s + A[r][k] * B[k][c];
`ifdef MAC_SATURATE_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
      end
    end
    t = s;
    return t[BITS_C-1:0];
  endfunction

  task automatic compute_ref();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        expc[r][c] = ref_elem(r, c, 0, -1);
  endtask

  task automatic fill_exp(input logic [BITS_C-1:0] v);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        expc[r][c] = v;
  endtask

  task automatic check_all(input string tag);
    logic [DIM-1:0][BITS_C-1:0] v;
    for (int r = 0; r < DIM; r++) begin
      Crow = ROWBITS'(r);
      #1;
      for (int c = 0; c < DIM; c++) v[c] = expc[r][c];
      check($sformatf("%s_row%0d", tag, r), 128'(Cout), 128'(v));
    end
  endtask

  task automatic clear_c();
    en = 1'b0;
    for (int r = 0; r < DIM; r++) begin
      WrEnC = 1'b1;
      Crow  = ROWBITS'(r);
      Cin   = '0;
      tick();
    end
    WrEnC = 1'b0;
  endtask

  // Full 3*DIM-cycle load protocol; optional 5-cycle en gap before cycle hold_at,
  // optional row-3 write of 5s coinciding with the en edge of cycle wrc_at.
  task automatic run_product(input int hold_at, input int wrc_at);
    for (int i = 0; i < 3 * DIM; i++) begin
      if (i == hold_at) begin
        en = 1'b0; WrEnA = 1'b0; Bin = '0;
        repeat (5) tick();
      end
      en = 1'b1;
      if (i < DIM) begin
        WrEnA = 1'b1;
        Arow  = ROWBITS'(i);
        for (int j = 0; j < DIM; j++) begin
          Ain[j] = 8'(A[i][j]);
          Bin[j] = 8'(B[i][j]);
        end
      end else begin
        WrEnA = 1'b0; Ain = '0; Bin = '0;
      end
      if (i == wrc_at) begin
        WrEnC = 1'b1;
        Crow  = 3'd3;
        for (int c = 0; c < DIM; c++) Cin[c] = 16'd5;
      end
      tick();
      if (i == wrc_at) begin
        check("wrc_priority_row3", 128'(Cout), 128'({DIM{16'd5}}));
        WrEnC = 1'b0;
      end
    end
    en = 1'b0; WrEnA = 1'b0;
  endtask

  task automatic randomize_ab();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        A[r][c] = int'($urandom_range(0, 255)) - 128;
        B[r][c] = int'($urandom_range(0, 255)) - 128;
      end
  endtask

  initial begin
    logic [DIM-1:0][BITS_AB-1:0] ea;
    logic [DIM-1:0][BITS_AB-1:0] eb;

    rst_n = 1'b0; en = 1'b0; WrEnA = 1'b0; Arow = '0; Ain = '0; Bin = '0;
    WrEnC = 1'b0; Crow = '0; Cin = '0;

    // Reset, then flush with zeros.
    tick();
    rst_n = 1'b1;
    en = 1'b1;
    repeat (DIM) tick();
    en = 1'b0;
    check("reset_aout", 128'(Aout), 128'(0));
    check("reset_bout", 128'(Bout), 128'(0));
    fill_exp('0);
    check_all("reset_c");

    // Skew timing with all-ones A and B.
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        A[r][c] = 1; B[r][c] = 1;
      end
    for (int e = 0; e < 3 * DIM; e++) begin
      en = 1'b1;
      if (e < DIM) begin
        WrEnA = 1'b1; Arow = ROWBITS'(e);
        for (int j = 0; j < DIM; j++) begin Ain[j] = 8'd1; Bin[j] = 8'd1; end
      end else begin
        WrEnA = 1'b0; Ain = '0; Bin = '0;
      end
      tick();
      for (int j = 0; j < DIM; j++) begin
        ea[j] = (e >= j && e <= j + DIM - 1) ? 8'd1 : 8'd0;
        eb[j] = ea[j];
      end
      check($sformatf("skew_aout_e%0d", e), 128'(Aout), 128'(ea));
      check($sformatf("skew_bout_e%0d", e), 128'(Bout), 128'(eb));
    end
    en = 1'b0; WrEnA = 1'b0;
    fill_exp(16'd8);
    check_all("ones_c");
    clear_c();
    fill_exp('0);
    check_all("clear_after_ones");

    // Identity A, B[k][c] = k*DIM + c.
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        A[r][c] = (r == c) ? 1 : 0;
        B[r][c] = r * DIM + c;
      end
    run_product(-1, -1);
    Crow = 3'd2;
    #1;
    check("ident_row2_first", 128'(Cout[0]), 128'(16));
    check("ident_row2_last", 128'(Cout[7]), 128'(23));
    compute_ref();
    check_all("ident_c");
    clear_c();

    // Signed extremes: -128*127 = -16256 = 0xC080; 8 * 0xC080 mod 2^16 = 0x0400.
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        A[r][c] = -128; B[r][c] = 127;
      end
    run_product(-1, -1);
`ifdef MAC_SATURATE_EN
    fill_exp(16'h8000);
`else
    fill_exp(16'h0400);
`endif
    check_all("signed_c");
    clear_c();

    // en gap mid-run must not change the result.
    randomize_ab();
    run_product(10, -1);
    compute_ref();
    check_all("hold_c");
    clear_c();

    // Write to row 3 at the en edge of cycle 12; row 3 keeps only later products.
    randomize_ab();
    run_product(-1, 12);
    compute_ref();
    for (int c = 0; c < DIM; c++) expc[3][c] = ref_elem(3, c, 5, 12);
    check_all("wrc_run_c");
    clear_c();

    // Random products, each followed by a host clear.
    for (int t = 0; t < 20; t++) begin
      randomize_ab();
      run_product(-1, -1);
      compute_ref();
      check_all($sformatf("rand%0d", t));
      clear_c();
      fill_exp('0);
      check_all($sformatf("rand%0d_clr", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
